// File: rtl/ds_operand_issue_pkg.sv
// Shared opcode/function constants and register-address width for the decode-stage issue block.
package ds_operand_issue_pkg;

   localparam int REG_W = 5;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MTHI = 6'h11;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MTLO = 6'h13;

endpackage

// File: rtl/ds_operand_issue_src_use_dec.sv
// Source-register use decoder: flags whether an instruction actually reads rs and/or rt.
module ds_src_use_dec
   import ds_operand_issue_pkg::*;
(
   input  logic [31:0] inst,
   output logic        rs_used,
   output logic        rt_used
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       is_special;
   logic       unused_bits;

   assign op          = inst[31:26];
   assign fn          = inst[5:0];
   assign is_special  = (op == OP_SPECIAL);
   assign unused_bits = ^inst[25:6];

   always_comb begin
      rs_used = 1'b1;
      if (op == OP_J || op == OP_JAL || op == OP_LUI)
         rs_used = 1'b0;
      else if (is_special && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA ||
                              fn == FN_MFHI || fn == FN_MFLO))
         rs_used = 1'b0;
   end

   always_comb begin
      rt_used = 1'b0;
      if (is_special)
         rt_used = !(fn == FN_JR || fn == FN_JALR || fn == FN_MTHI ||
                     fn == FN_MTLO || fn == FN_MFHI || fn == FN_MFLO);
      else if (op == OP_BEQ || op == OP_BNE || op == OP_SW || op == OP_SH || op == OP_SB)
         rt_used = 1'b1;
   end

endmodule

// File: rtl/ds_operand_issue.sv
// Decode-stage issue: holds inst/PC, resolves rs/rt through prioritised forwarding channels
// with load-use interlock and per-operand capture. Optional stall counter: DS_STALL_CNT_EN.
module ds_operand_issue
   import ds_operand_issue_pkg::*;
#(
   parameter int FWD_N  = 3,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fs_to_ds_valid,
   input  logic [31:0]             fs_inst,
   input  logic [PC_W-1:0]         fs_pc,
   output logic                    ds_allowin,
   input  logic                    es_allowin,
   output logic                    ds_to_es_valid,
   output logic [31:0]             ds_inst,
   output logic [PC_W-1:0]         ds_pc,
   output logic [DATA_W-1:0]       rs_value,
   output logic [DATA_W-1:0]       rt_value,
   input  logic                    flush,
   output logic [REG_W-1:0]        rf_raddr1,
   output logic [REG_W-1:0]        rf_raddr2,
   input  logic [DATA_W-1:0]       rf_rdata1,
   input  logic [DATA_W-1:0]       rf_rdata2,
   input  logic [FWD_N-1:0]        fwd_valid,
   input  logic [REG_W*FWD_N-1:0]  fwd_dest,
   input  logic [FWD_N-1:0]        fwd_ready,
   input  logic [DATA_W*FWD_N-1:0] fwd_data
`ifdef DS_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cycles
`endif
);

   logic                   ds_valid_reg;
   logic [31:0]            ds_inst_reg;
   logic [PC_W-1:0]        ds_pc_reg;
   logic                   rs_used;
   logic                   rt_used;
   logic [1:0]             op_used;
   logic [1:0]             op_ok;
   logic [1:0][DATA_W-1:0] op_rf;
   logic [1:0][DATA_W-1:0] op_val;
   logic                   ds_ready_go;
   logic                   fire;
   logic                   load;

   ds_src_use_dec u_src_use_dec (
      .inst    (ds_inst_reg),
      .rs_used (rs_used),
      .rt_used (rt_used)
   );

   assign op_used = {rt_used, rs_used};
   assign op_rf   = {rf_rdata2, rf_rdata1};

   // Operand 0 is rs (inst[25:21]), operand 1 is rt (inst[20:16]).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_op
         localparam int ADDR_LSB = (gi == 0) ? 21 : 16;
         logic [REG_W-1:0]  addr;
         logic [DATA_W-1:0] live_val;
         logic              live_ok;
         logic              cap_reg;
         logic [DATA_W-1:0] hold_reg;

         assign addr = ds_inst_reg[ADDR_LSB +: REG_W];

         // Scan oldest to youngest so the lowest-index hit overrides the rest.
         always_comb begin
            live_val = op_rf[gi];
            live_ok  = 1'b1;
            if (addr == '0) begin
               live_val = '0;
            end else begin
               for (int i = FWD_N - 1; i >= 0; i--) begin
                  if (fwd_valid[i] && fwd_dest[REG_W*i +: REG_W] == addr) begin
                     live_val = fwd_data[DATA_W*i +: DATA_W];
                     live_ok  = fwd_ready[i];
                  end
               end
            end
            if (!op_used[gi])
               live_ok = 1'b1;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cap_reg  <= 1'b0;
               hold_reg <= '0;
            end else if (flush || fire || load) begin
               cap_reg  <= 1'b0;
            end else if (ds_valid_reg && live_ok && !cap_reg) begin
               cap_reg  <= 1'b1;
               hold_reg <= live_val;
            end
         end

         assign op_ok[gi]  = cap_reg | live_ok;
         assign op_val[gi] = cap_reg ? hold_reg : live_val;
      end
   endgenerate

   assign ds_ready_go    = &op_ok;
   assign ds_to_es_valid = ds_valid_reg & ds_ready_go & !flush;
   assign fire           = ds_to_es_valid & es_allowin;
   assign ds_allowin     = !ds_valid_reg | fire;
   assign load           = fs_to_ds_valid & ds_allowin & !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid_reg <= 1'b0;
         ds_inst_reg  <= '0;
         ds_pc_reg    <= '0;
      end else if (flush) begin
         ds_valid_reg <= 1'b0;
      end else if (ds_allowin) begin
         ds_valid_reg <= fs_to_ds_valid;
         if (fs_to_ds_valid) begin
            ds_inst_reg <= fs_inst;
            ds_pc_reg   <= fs_pc;
         end
      end
   end

   assign ds_inst   = ds_inst_reg;
   assign ds_pc     = ds_pc_reg;
   assign rs_value  = op_val[0];
   assign rt_value  = op_val[1];
   assign rf_raddr1 = ds_inst_reg[25:21];
   assign rf_raddr2 = ds_inst_reg[20:16];

`ifdef DS_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_reg <= '0;
      else if (ds_valid_reg && !ds_ready_go && !flush && stall_cnt_reg != 32'hFFFF_FFFF)
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign stall_cycles = stall_cnt_reg;
`endif

endmodule
